// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared defaults and the lock-state encoding for the video timing
// measurement block.
//   CW_DEF          default counter / measurement width
//   LOCK_FRAMES_DEF default number of identical frames needed for lock
//   lock_state_e    UNLOCKED / LOCKED
package video_timing_pkg;

  localparam int CW_DEF          = 10;
  localparam int LOCK_FRAMES_DEF = 4;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/edge_det.sv
// edge_det
// Registers one timing input on each enabled sample and flags rising and
// falling edges against the previously registered sample.
//   clk, reset_n  clock, synchronous active-low reset
//   en            sample enable (pixel enable)
//   d             timing input
//   rise, fall    one-sample edge flags, only valid while en is high
module edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q, d_d;

  always_comb begin
    d_d = en ? d : d_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) d_q <= 1'b0;
    else          d_q <= d_d;
  end

  assign rise = en &  d & ~d_q;
  assign fall = en & ~d &  d_q;

endmodule

// File: rtl/video_timing_meas.sv
// video_timing_meas
// Rebuilds pixel/line counters from an incoming hsync/vsync/hbl/vbl timing
// interface, measures line and frame geometry, publishes it once per frame
// and reports lock once the geometry has been stable for LOCK_FRAMES frames.
//   clk, reset_n                  clock, synchronous active-low reset
//   clk_pix                       pixel enable; nothing but frame_strobe moves while low
//   hsync, vsync, hbl, vbl        timing inputs, active-high
//   hc, vc                        reconstructed pixel / line index (0 = first active)
//   h_total, h_active, hs_start   published line measurements
//   v_total, v_active, vs_start   published frame measurements
//   locked                        timing stable
//   frame_strobe                  one-clk pulse with each publish
module video_timing_meas
  import video_timing_pkg::*;
#(
  parameter int CW          = CW_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clk_pix,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          hbl,
  input  logic          vbl,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] hs_start,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic [CW-1:0] vs_start,
  output logic          locked,
  output logic          frame_strobe
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam int            SW      = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [SW-1:0] STB_MAX = SW'(LOCK_FRAMES);

  // edge detectors: [0] hsync, [1] vsync, [2] hbl, [3] vbl
  logic [3:0] sig_in, rise, fall;
  assign sig_in = {vbl, hbl, vsync, hsync};

  edge_det u_edge [3:0] (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (clk_pix),
    .d      (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  logic hs_rise, vs_rise, hbl_rise, hbl_fall, vbl_rise, vbl_fall;
  assign hs_rise  = rise[0];
  assign vs_rise  = rise[1];
  assign hbl_rise = rise[2];
  assign hbl_fall = fall[2];
  assign vbl_rise = rise[3];
  assign vbl_fall = fall[3];

  // sync falling edges carry no measurement
  logic unused_sync_fall;
  assign unused_sync_fall = &{1'b0, fall[1:0]};

  logic [CW-1:0] px_q, px_d, ln_q, ln_d, px_inc, ln_inc;
  logic [CW-1:0] ht_sh_q, ht_sh_d, ha_sh_q, ha_sh_d, hs_sh_q, hs_sh_d;
  logic [CW-1:0] vt_sh_q, vt_sh_d, va_sh_q, va_sh_d, vs_sh_q, vs_sh_d;
  logic [CW-1:0] h_total_q, h_total_d, h_active_q, h_active_d, hs_start_q, hs_start_d;
  logic [CW-1:0] v_total_q, v_total_d, v_active_q, v_active_d, vs_start_q, vs_start_d;
  logic [SW-1:0] stable_q, stable_d;
  logic          pub_vld_q, pub_vld_d, frame_strobe_q, frame_strobe_d;
  logic          publish, same_geom, timeout;
  lock_state_e   state_q, state_d;

  // event index of the current sample is previous count + 1, saturating
  assign px_inc = (px_q == CNT_MAX) ? CNT_MAX : px_q + CW'(1);
  assign ln_inc = (ln_q == CNT_MAX) ? CNT_MAX : ln_q + CW'(1);

  assign publish   = vbl_fall;
  // compare against the values about to be published (this sample's captures)
  assign same_geom = pub_vld_q && (ht_sh_d == h_total_q) && (vt_sh_d == v_total_q);
  assign timeout   = clk_pix && ((px_q == CNT_MAX) || (ln_q == CNT_MAX));

  always_comb begin
    px_d = px_q;        ln_d = ln_q;
    ht_sh_d = ht_sh_q;  ha_sh_d = ha_sh_q;  hs_sh_d = hs_sh_q;
    vt_sh_d = vt_sh_q;  va_sh_d = va_sh_q;  vs_sh_d = vs_sh_q;
    h_total_d = h_total_q;  h_active_d = h_active_q;  hs_start_d = hs_start_q;
    v_total_d = v_total_q;  v_active_d = v_active_q;  vs_start_d = vs_start_q;
    stable_d = stable_q;
    pub_vld_d = pub_vld_q;
    frame_strobe_d = 1'b0;
    if (clk_pix) begin
      px_d = hbl_fall ? '0 : px_inc;
      if (hbl_fall) ht_sh_d = px_inc;
      if (hbl_rise) ha_sh_d = px_inc;
      // hsync on the hbl-fall sample belongs to index 0 of the new line
      if (hs_rise)  hs_sh_d = hbl_fall ? '0 : px_inc;
      // line counter advances on hbl-fall; vbl-fall clear wins over increment
      if (hbl_fall) ln_d = vbl_fall ? '0 : ln_inc;
      if (vbl_rise) va_sh_d = ln_inc;
      if (vs_rise)  vs_sh_d = ln_inc;
      if (vbl_fall) vt_sh_d = ln_inc;   // pre-clear line count
      if (publish) begin
        h_total_d  = ht_sh_d;  h_active_d = ha_sh_d;  hs_start_d = hs_sh_d;
        v_total_d  = vt_sh_d;  v_active_d = va_sh_d;  vs_start_d = vs_sh_d;
        frame_strobe_d = 1'b1;
        pub_vld_d      = 1'b1;
        // first publish after reset has nothing valid to compare against
        if (same_geom) stable_d = (stable_q == STB_MAX) ? stable_q : stable_q + SW'(1);
        else           stable_d = '0;
      end
      if (timeout) stable_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      px_q <= '0;  ln_q <= '0;
      ht_sh_q <= '0;  ha_sh_q <= '0;  hs_sh_q <= '0;
      vt_sh_q <= '0;  va_sh_q <= '0;  vs_sh_q <= '0;
      h_total_q <= '0;  h_active_q <= '0;  hs_start_q <= '0;
      v_total_q <= '0;  v_active_q <= '0;  vs_start_q <= '0;
      stable_q <= '0;  pub_vld_q <= 1'b0;  frame_strobe_q <= 1'b0;
    end else begin
      px_q <= px_d;  ln_q <= ln_d;
      ht_sh_q <= ht_sh_d;  ha_sh_q <= ha_sh_d;  hs_sh_q <= hs_sh_d;
      vt_sh_q <= vt_sh_d;  va_sh_q <= va_sh_d;  vs_sh_q <= vs_sh_d;
      h_total_q <= h_total_d;  h_active_q <= h_active_d;  hs_start_q <= hs_start_d;
      v_total_q <= v_total_d;  v_active_q <= v_active_d;  vs_start_q <= vs_start_d;
      stable_q <= stable_d;  pub_vld_q <= pub_vld_d;  frame_strobe_q <= frame_strobe_d;
    end
  end

  // lock FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= UNLOCKED;
    else          state_q <= state_d;
  end

  // lock FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (!timeout && clk_pix && publish && stable_d == STB_MAX) state_d = LOCKED;
      LOCKED:   if (timeout || (clk_pix && publish && !same_geom))         state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  // lock FSM: outputs
  always_comb begin
    locked = (state_q == LOCKED);
  end

  assign hc           = px_q;
  assign vc           = ln_q;
  assign h_total      = h_total_q;
  assign h_active     = h_active_q;
  assign hs_start     = hs_start_q;
  assign v_total      = v_total_q;
  assign v_active     = v_active_q;
  assign vs_start     = vs_start_q;
  assign frame_strobe = frame_strobe_q;

endmodule
